huff_feed_ctrl: RTL and testbench

Sequencer that feeds the Huffman shift-register decoder from a packed word stream.
- Accepts 16-bit codeword-stream words over a valid/ready handshake.
- Slices each word MSB-first into chunks of up to 4 bits and issues them to the decoder's sValid/in_bits/in_len port only when the decoder reports buffer room.
- Counts decoded symbols (tvalid) against a programmed total, forwards them, and signals done or error.

---
 rtl/huff_pkg.sv | 30 +++
 rtl/huff_word_slicer.sv | 54 +++++
 rtl/huff_feed_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_huff_feed_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
`default_nettype none
// ============================================================================
// Package  : huff_pkg
// Purpose  : Shared widths, FSM encoding and symbol type for the Huffman feeder
// Revision : 1.0 - initial release
// ============================================================================
package huff_pkg;

  localparam int WORD_W  = 16;
  localparam int CHUNK_W = 4;
  localparam int LEN_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef logic signed [3:0] sym_t;

  // Only the final word may be short; 0 or out-of-range counts mean a full word.
  function automatic logic [4:0] eff_nbits(input logic last, input logic [4:0] nbits);
    if (!last || nbits == 5'd0 || nbits > 5'(WORD_W)) return 5'(WORD_W);
    return nbits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/huff_word_slicer.sv
`default_nettype none
// ============================================================================
// Module   : huff_word_slicer
// Purpose  : Holds one packed word and hands it out MSB-first in <=CHUNK_W slices
// Revision : 1.0 - initial release
// ============================================================================
module huff_word_slicer #(
  parameter int WORD_W  = 16,
  parameter int CHUNK_W = 4,
  parameter int LEN_W   = 3,
  parameter int LEFT_W  = $clog2(WORD_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [WORD_W-1:0]  i_data,
  input  logic [LEFT_W-1:0]  i_nbits,
  input  logic               i_take,
  input  logic               i_clear,
  output logic [CHUNK_W-1:0] o_bits,
  output logic [LEN_W-1:0]   o_len,
  output logic               o_empty,
  output logic               o_final
);

  logic [WORD_W-1:0]  r_hold;
  logic [LEFT_W-1:0]  r_left;
  logic [CHUNK_W-1:0] w_top;

  always_comb begin
    w_top = r_hold[WORD_W-1 -: CHUNK_W];
    if (r_left >= LEFT_W'(CHUNK_W)) o_len = LEN_W'(CHUNK_W);
    else                            o_len = LEN_W'(r_left);
    // Short tail chunk: drop the unused low bits so the value is right-aligned.
    o_bits  = w_top >> (LEN_W'(CHUNK_W) - o_len);
    o_empty = (r_left == '0);
    o_final = !o_empty && (r_left <= LEFT_W'(CHUNK_W));
  end

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_hold <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_hold <= i_data;
      r_left <= i_nbits;
    end else if (i_take) begin
      r_hold <= r_hold << o_len;
      r_left <= r_left - LEFT_W'(o_len);
    end
  end

endmodule
`default_nettype wire

// File: rtl/huff_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : huff_feed_ctrl
// Purpose  : Feeds packed codeword words to the Huffman decoder and counts symbols
// Revision : 1.0 - initial release
// ============================================================================
module huff_feed_ctrl #(
  parameter int WORD_W    = 16,
  parameter int CHUNK_W   = 4,
  parameter int LEN_W     = 3,
  parameter int CNT_W     = 16,
  parameter int DRAIN_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    sym_total,
  input  logic                w_valid,
  input  logic [WORD_W-1:0]   w_data,
  input  logic                w_last,
  input  logic [4:0]          w_nbits,
  output logic                w_ready,
  input  logic                dec_ready,
  output logic                dec_sValid,
  output logic [CHUNK_W-1:0]  dec_bits,
  output logic [LEN_W-1:0]    dec_len,
  input  logic                dec_tvalid,
  input  logic signed [3:0]   dec_data,
  output logic                out_valid,
  output logic signed [3:0]   out_data,
  output logic [CNT_W-1:0]    sym_count,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import huff_pkg::*;

  localparam int LEFT_W = $clog2(WORD_W + 1);
  localparam int IDLE_W = $clog2(DRAIN_MAX + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_count;
  logic               r_last;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_w_ready;
  logic               r_sValid;
  logic [CHUNK_W-1:0] r_bits;
  logic [LEN_W-1:0]   r_len;
  logic               r_out_valid;
  sym_t               r_out_data;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_sym;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_term;
  logic               w_hs;
  logic               w_load;
  logic               w_take;
  logic               w_timeout;
  logic [CHUNK_W-1:0] w_chunk_bits;
  logic [LEN_W-1:0]   w_chunk_len;
  logic               w_empty;
  logic               w_final;

  always_comb begin
    w_sym     = dec_tvalid && (r_state == S_FETCH || r_state == S_FEED || r_state == S_DRAIN);
    w_cnt_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);
    w_term    = w_sym && (w_cnt_inc == r_total);
    w_hs      = (r_state == S_FETCH) && w_valid && r_w_ready;
    w_load    = w_hs && !w_term;
    // r_sValid gap guarantees dec_ready reflects the previous chunk.
    w_take    = (r_state == S_FEED) && dec_ready && !r_sValid && !w_empty && !w_term;
    w_timeout = (r_state == S_DRAIN) && !dec_tvalid && (r_idle == IDLE_W'(DRAIN_MAX - 1));
  end

  huff_word_slicer #(
    .WORD_W  (WORD_W),
    .CHUNK_W (CHUNK_W),
    .LEN_W   (LEN_W),
    .LEFT_W  (LEFT_W)
  ) u_slicer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_data),
    .i_nbits (LEFT_W'(eff_nbits(w_last, w_nbits))),
    .i_take  (w_take),
    .i_clear (w_term),
    .o_bits  (w_chunk_bits),
    .o_len   (w_chunk_len),
    .o_empty (w_empty),
    .o_final (w_final)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_total     <= '0;
      r_count     <= '0;
      r_last      <= 1'b0;
      r_idle      <= '0;
      r_w_ready   <= 1'b0;
      r_sValid    <= 1'b0;
      r_bits      <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sValid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_sym) begin
        r_out_valid <= 1'b1;
        r_out_data  <= dec_data;
        r_count     <= w_cnt_inc;
      end
      // Job end pre-empts any handshake or chunk issue in the same cycle.
      if (w_term || w_timeout) begin
        r_state   <= S_DONE;
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
        r_w_ready <= 1'b0;
        if (w_timeout) r_err <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_total <= sym_total;
              r_count <= '0;
              r_err   <= 1'b0;
              if (sym_total != '0) begin
                r_state   <= S_FETCH;
                r_busy    <= 1'b1;
                r_w_ready <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (w_hs) begin
              r_state   <= S_FEED;
              r_w_ready <= 1'b0;
              r_last    <= w_last;
            end
          end
          S_FEED: begin
            if (w_take) begin
              r_sValid <= 1'b1;
              r_bits   <= w_chunk_bits;
              r_len    <= w_chunk_len;
              if (w_final) begin
                r_idle <= '0;
                if (r_last) begin
                  r_state <= S_DRAIN;
                end else begin
                  r_state   <= S_FETCH;
                  r_w_ready <= 1'b1;
                end
              end
            end
          end
          S_DRAIN: r_idle <= dec_tvalid ? '0 : r_idle + IDLE_W'(1);
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_ready    = r_w_ready;
  assign dec_sValid = r_sValid;
  assign dec_bits   = r_bits;
  assign dec_len    = r_len;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign sym_count  = r_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_huff_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_huff_feed_ctrl
// Purpose  : Self-checking bench for huff_feed_ctrl against a bit-queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_huff_feed_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [15:0] sym_total = '0;
  logic w_valid = 1'b0;
  logic [15:0] w_data = '0;
  logic w_last = 1'b0;
  logic [4:0] w_nbits = '0;
  logic w_ready;
  logic dec_ready = 1'b0;
  logic dec_sValid;
  logic [3:0] dec_bits;
  logic [2:0] dec_len;
  logic dec_tvalid = 1'b0;
  logic signed [3:0] dec_data = '0;
  logic out_valid;
  logic signed [3:0] out_data;
  logic [15:0] sym_count;
  logic busy, done, err;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  huff_feed_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .sym_total(sym_total),
    .w_valid(w_valid), .w_data(w_data), .w_last(w_last), .w_nbits(w_nbits),
    .w_ready(w_ready), .dec_ready(dec_ready), .dec_sValid(dec_sValid),
    .dec_bits(dec_bits), .dec_len(dec_len), .dec_tvalid(dec_tvalid),
    .dec_data(dec_data), .out_valid(out_valid), .out_data(out_data),
    .sym_count(sym_count), .busy(busy), .done(done), .err(err)
  );

  // Job description
  logic [15:0] jw[$];
  logic [4:0]  jnb;
  int          sched[$];
  logic signed [3:0] jd[$];
  int          rdy_mode;
  int          wgap;
  // Model and observations
  logic [3:0] ex_bits[$];
  int         ex_len[$];
  logic [3:0] ob_bits[$];
  int         ob_len[$];
  int         ob_cyc[$];
  int         hs_at[$];
  logic signed [3:0] sent[$];
  logic signed [3:0] got[$];
  int done_seen, done_hi, done_cyc, busy_at_done, err_at_done, cnt_at_done;
  int sv_post, ov_post, cnt_post, err_after_start, wr_hi;
  int bp_sv, bp_chg, bp_lat;

  // Concatenate the valid bits of all words, then cut into 4-bit pieces.
  task automatic build_model();
    bit q[$];
    int neff, n, l;
    logic [3:0] v;
    ex_bits.delete();
    ex_len.delete();
    neff = (jnb == 0 || jnb > 16) ? 16 : int'(jnb);
    foreach (jw[i]) begin
      n = (i == jw.size() - 1) ? neff : 16;
      for (int b = 0; b < n; b++) q.push_back(jw[i][15-b]);
    end
    while (q.size() > 0) begin
      l = (q.size() < 4) ? q.size() : 4;
      v = 4'd0;
      for (int b = 0; b < l; b++) v = {v[2:0], q.pop_front()};
      ex_bits.push_back(v);
      ex_len.push_back(l);
    end
  endtask

  // Acts as word source and decoder; records everything the DUT emits.
  task automatic run_job(input int total);
    int wi, chunks, hs, st_cyc, rise_cyc;
    logic [3:0] sb;
    ob_bits.delete(); ob_len.delete(); ob_cyc.delete(); hs_at.delete();
    sent.delete(); got.delete();
    done_seen = 0; done_hi = 0; done_cyc = -1; sv_post = 0; ov_post = 0; wr_hi = 0;
    bp_sv = 0; bp_chg = 0; bp_lat = -1;
    wi = 0; chunks = 0; hs = 0; st_cyc = -100; rise_cyc = -1; sb = '0;
    @(negedge clk);
    start = 1'b1;
    sym_total = 16'(total);
    for (int cyc = 0; cyc < 600 && done_seen == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        err_after_start = err;
      end
      if (cyc > st_cyc && cyc <= st_cyc + 6) begin
        if (dec_sValid) bp_sv++;
        if (dec_bits !== sb) bp_chg++;
      end
      if (dec_sValid) begin
        ob_bits.push_back(dec_bits);
        ob_len.push_back(int'(dec_len));
        ob_cyc.push_back(cyc);
        chunks++;
        if (rise_cyc >= 0 && bp_lat < 0) bp_lat = cyc - rise_cyc;
      end
      if (out_valid) got.push_back(out_data);
      if (w_ready) wr_hi++;
      if (done) begin
        done_seen = 1; done_hi++; done_cyc = cyc;
        busy_at_done = busy; err_at_done = err; cnt_at_done = sym_count;
      end
      if (hs != 0) wi++;
      hs = 0;
      if (done_seen != 0) begin
        w_valid = 1'b0;
        dec_ready = 1'b1;
        dec_tvalid = 1'b1;   // lands in DONE: must be ignored
        dec_data = 4'sd3;
      end else begin
        w_valid = (wi < jw.size()) && (wgap == 0 || $urandom_range(0, 3) != 0);
        if (wi < jw.size()) begin
          w_data = jw[wi];
          w_last = (wi == jw.size() - 1);
          w_nbits = w_last ? jnb : 5'($urandom);
        end
        if (w_valid && w_ready) begin
          hs = 1;
          hs_at.push_back(chunks);
        end
        if (rdy_mode == 2 && chunks == 1 && st_cyc < 0) begin
          st_cyc = cyc;
          sb = dec_bits;
        end
        if (rdy_mode == 1) dec_ready = ($urandom_range(0, 3) != 0);
        else if (cyc >= st_cyc && cyc < st_cyc + 6) dec_ready = 1'b0;
        else begin
          dec_ready = 1'b1;
          if (cyc == st_cyc + 6) rise_cyc = cyc;
        end
        if (sched.size() > 0 && sched[0] <= chunks) begin
          void'(sched.pop_front());
          dec_tvalid = 1'b1;
          dec_data = (jd.size() > 0) ? jd.pop_front() : 4'($urandom);
          sent.push_back(dec_data);
        end else begin
          dec_tvalid = 1'b0;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dec_sValid) sv_post++;
      if (out_valid) ov_post++;
      if (done) done_hi++;
      dec_tvalid = (k < 2);
      dec_data = 4'sd3;
    end
    dec_tvalid = 1'b0;
    cnt_post = sym_count;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; w_valid = 1'b1; sym_total = 16'd5; dec_tvalid = 1'b1; dec_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({w_ready, dec_sValid, dec_bits, dec_len, out_valid, out_data, sym_count, busy, done, err} !== 32'd0) begin
      n_err++; $display("FAIL reset_outputs: got w_ready=%b sv=%b bits=%h len=%0d ov=%b od=%0d cnt=%0d busy=%b done=%b err=%b want all 0",
                        w_ready, dec_sValid, dec_bits, dec_len, out_valid, out_data, sym_count, busy, done, err);
    end
    reset = 1'b1; start = 1'b0; w_valid = 1'b0; dec_tvalid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, w_ready, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_idle: got busy/w_ready/done=%b%b%b want 000", busy, w_ready, done);
    end
  endtask

  task automatic test_single();
    jw = '{16'b1111_0101_0110_0000}; jnb = 5'd11; sched = '{1, 2, 3};
    jd = '{-4'sd1, 4'sd2, 4'sd5}; rdy_mode = 0; wgap = 0;
    build_model();
    run_job(3);
    n_chk++; if (done_seen != 1) begin n_err++; $display("FAIL single_done: got %0d want 1", done_seen); end
    n_chk++; if (ob_bits.size() != 3) begin n_err++; $display("FAIL single_nchunk: got %0d want 3", ob_bits.size()); end
    foreach (ex_bits[i]) if (i < ob_bits.size()) begin
      n_chk++;
      if (ob_bits[i] !== ex_bits[i] || ob_len[i] != ex_len[i]) begin
        n_err++; $display("FAIL single_chunk%0d: got %h/%0d want %h/%0d", i, ob_bits[i], ob_len[i], ex_bits[i], ex_len[i]);
      end
    end
    for (int i = 1; i < ob_cyc.size(); i++) begin
      n_chk++; if (ob_cyc[i] - ob_cyc[i-1] != 2) begin n_err++; $display("FAIL single_spacing%0d: got %0d want 2", i, ob_cyc[i] - ob_cyc[i-1]); end
    end
    n_chk++;
    if (got.size() != 3 || got[0] !== -4'sd1 || got[1] !== 4'sd2 || got[2] !== 4'sd5) begin
      n_err++; $display("FAIL single_symbols: got n=%0d want -1,2,5", got.size());
    end
    n_chk++; if (cnt_at_done != 3) begin n_err++; $display("FAIL single_count: got %0d want 3", cnt_at_done); end
    n_chk++; if (busy_at_done != 0 || done_hi != 1) begin n_err++; $display("FAIL single_busy_pulse: got busy=%0d pulses=%0d want 0,1", busy_at_done, done_hi); end
    n_chk++; if (ov_post != 0 || cnt_post != 3) begin n_err++; $display("FAIL single_idle_ignore: got ov=%0d cnt=%0d want 0,3", ov_post, cnt_post); end
  endtask

  task automatic test_backpressure();
    jw = '{16'h1234}; jnb = 5'd16; sched = '{4}; rdy_mode = 2; wgap = 0;
    build_model();
    run_job(1);
    n_chk++; if (bp_sv != 0) begin n_err++; $display("FAIL bp_no_strobe: got %0d strobes want 0", bp_sv); end
    n_chk++; if (bp_chg != 0) begin n_err++; $display("FAIL bp_bits_stable: got %0d changes want 0", bp_chg); end
    n_chk++; if (bp_lat != 1) begin n_err++; $display("FAIL bp_latency: got %0d want 1", bp_lat); end
    n_chk++; if (ob_bits.size() != ex_bits.size()) begin n_err++; $display("FAIL bp_nchunk: got %0d want %0d", ob_bits.size(), ex_bits.size()); end
    foreach (ex_bits[i]) if (i < ob_bits.size()) begin
      n_chk++;
      if (ob_bits[i] !== ex_bits[i] || ob_len[i] != ex_len[i]) begin
        n_err++; $display("FAIL bp_chunk%0d: got %h/%0d want %h/%0d", i, ob_bits[i], ob_len[i], ex_bits[i], ex_len[i]);
      end
    end
  endtask

  task automatic test_multi_word();
    jw = '{16'hF0F0, 16'hA5A5}; jnb = 5'd0; sched = '{3, 8}; rdy_mode = 0; wgap = 0;
    build_model();
    run_job(2);
    n_chk++; if (ob_bits.size() != 8) begin n_err++; $display("FAIL multi_nchunk: got %0d want 8", ob_bits.size()); end
    foreach (ex_bits[i]) if (i < ob_bits.size()) begin
      n_chk++;
      if (ob_bits[i] !== ex_bits[i] || ob_len[i] != 4) begin
        n_err++; $display("FAIL multi_chunk%0d: got %h/%0d want %h/4", i, ob_bits[i], ob_len[i], ex_bits[i]);
      end
    end
    n_chk++;
    if (hs_at.size() != 2 || hs_at[0] != 0 || hs_at[1] != 4) begin
      n_err++; $display("FAIL multi_accept: got %0d handshakes (second after %0d chunks) want 2 after 4",
                        hs_at.size(), (hs_at.size() > 1) ? hs_at[1] : -1);
    end
    n_chk++; if (wr_hi != 2) begin n_err++; $display("FAIL multi_wready: got %0d high cycles want 2", wr_hi); end
    n_chk++; if (cnt_at_done != 2 || done_seen != 1) begin n_err++; $display("FAIL multi_done: got cnt=%0d done=%0d want 2,1", cnt_at_done, done_seen); end
  endtask

  task automatic test_early();
    jw = '{16'hBEEF}; jnb = 5'd16; sched = '{1}; rdy_mode = 0; wgap = 0;
    run_job(1);
    n_chk++; if (ob_bits.size() != 1 || sv_post != 0) begin n_err++; $display("FAIL early_chunks: got %0d+%0d want 1+0", ob_bits.size(), sv_post); end
    n_chk++; if (ob_bits.size() > 0 && ob_bits[0] !== 4'hB) begin n_err++; $display("FAIL early_bits: got %h want b", ob_bits[0]); end
    n_chk++; if (done_cyc != ob_cyc[0] + 1) begin n_err++; $display("FAIL early_latency: got done at %0d want %0d", done_cyc, ob_cyc[0] + 1); end
    n_chk++; if (err_at_done != 0 || cnt_at_done != 1) begin n_err++; $display("FAIL early_status: got err=%0d cnt=%0d want 0,1", err_at_done, cnt_at_done); end
  endtask

  task automatic test_timeout();
    jw = '{16'h3C3C}; jnb = 5'd16; sched = '{1, 2}; rdy_mode = 0; wgap = 0;
    run_job(5);
    n_chk++; if (done_seen != 1 || err_at_done != 1) begin n_err++; $display("FAIL timeout_err: got done=%0d err=%0d want 1,1", done_seen, err_at_done); end
    n_chk++; if (cnt_at_done != 2) begin n_err++; $display("FAIL timeout_count: got %0d want 2", cnt_at_done); end
    n_chk++;
    if (ob_cyc.size() != 4 || done_cyc - ob_cyc[ob_cyc.size()-1] != 16) begin
      n_err++; $display("FAIL timeout_delay: got %0d chunks, %0d cycles want 4, 16", ob_cyc.size(),
                        (ob_cyc.size() > 0) ? done_cyc - ob_cyc[ob_cyc.size()-1] : -1);
    end
    n_chk++; if (done_hi != 1) begin n_err++; $display("FAIL timeout_pulse: got %0d want 1", done_hi); end
    n_chk++; if (err !== 1'b1) begin n_err++; $display("FAIL timeout_hold: got %b want 1", err); end
    jw = '{16'h8000}; jnb = 5'd1; sched = '{1}; rdy_mode = 0; wgap = 0;
    run_job(1);
    n_chk++; if (err_after_start != 0 || err_at_done != 0) begin n_err++; $display("FAIL timeout_clear: got %0d/%0d want 0/0", err_after_start, err_at_done); end
    n_chk++; if (ob_len.size() != 1 || ob_len[0] != 1 || ob_bits[0] !== 4'h1) begin n_err++; $display("FAIL one_bit_chunk: got n=%0d want 1x(1,1)", ob_len.size()); end
  endtask

  task automatic test_zero_total();
    jw.delete(); jnb = 5'd0; sched.delete(); rdy_mode = 0; wgap = 0;
    run_job(0);
    n_chk++; if (done_cyc != 0 || done_hi != 1) begin n_err++; $display("FAIL zero_done: got cyc=%0d pulses=%0d want 0,1", done_cyc, done_hi); end
    n_chk++; if (cnt_at_done != 0 || busy_at_done != 0 || wr_hi != 0) begin n_err++; $display("FAIL zero_status: got cnt=%0d busy=%0d wr=%0d want 0", cnt_at_done, busy_at_done, wr_hi); end
  endtask

  task automatic test_random();
    int nw, nch, total;
    for (int it = 0; it < 6; it++) begin
      jw.delete(); sched.delete(); jd.delete();
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) jw.push_back(16'($urandom));
      jnb = 5'($urandom_range(0, 31));
      rdy_mode = 1; wgap = 1;
      build_model();
      nch = ex_bits.size();
      total = $urandom_range(1, 4);
      for (int k = 0; k < total - 1; k++) sched.push_back($urandom_range(0, nch));
      sched.sort();
      sched.push_back(nch);
      run_job(total);
      n_chk++; if (done_seen != 1 || cnt_at_done != total || err_at_done != 0) begin
        n_err++; $display("FAIL rand%0d_done: got done=%0d cnt=%0d err=%0d want 1,%0d,0", it, done_seen, cnt_at_done, err_at_done, total);
      end
      n_chk++; if (ob_bits.size() != nch) begin n_err++; $display("FAIL rand%0d_nchunk: got %0d want %0d", it, ob_bits.size(), nch); end
      foreach (ex_bits[i]) if (i < ob_bits.size()) begin
        n_chk++;
        if (ob_bits[i] !== ex_bits[i] || ob_len[i] != ex_len[i]) begin
          n_err++; $display("FAIL rand%0d_chunk%0d: got %h/%0d want %h/%0d", it, i, ob_bits[i], ob_len[i], ex_bits[i], ex_len[i]);
        end
      end
      n_chk++; if (got != sent) begin n_err++; $display("FAIL rand%0d_symbols: got %0d forwarded want %0d", it, got.size(), sent.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_multi_word();
    test_early();
    test_timeout();
    test_zero_total();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
